// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - iterative-latency multiply/divide unit owning HI/LO; optional madd/maddu under MDU_MADD_EN
module mdu_seq #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic        Start,
  input  logic [2:0]  MDUCtrl,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        Busy
);

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MADDU = 3'd7;
`endif

  // cnt_q == 0 is IDLE, anything else is RUN with that many cycles left
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] pend_q, pend_d;

  logic        is_long;
  logic        is_div;
  logic [63:0] result;

  // Products: the low 64 bits of a sign-extended 64x64 product equal the signed 32x32 product
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  assign prod_s = {{32{SrcA[31]}}, SrcA} * {{32{SrcB[31]}}, SrcB};
  assign prod_u = {32'd0, SrcA} * {32'd0, SrcB};

  // Division works on magnitudes; signs are restored afterwards so the quotient
  // truncates toward zero and the remainder follows the dividend. The 0x80000000 / -1
  // case falls out naturally: |q| = 0x80000000 negates to itself and r = 0.
  logic        div_signed;
  logic        neg_q, neg_r;
  logic [31:0] dvd_mag, dvs_mag, dvs_safe;
  logic [31:0] uq, ur, quo, rem;

  assign div_signed = (MDUCtrl == OP_DIV);
  assign neg_r      = div_signed & SrcA[31];
  assign neg_q      = div_signed & (SrcA[31] ^ SrcB[31]);
  assign dvd_mag    = (div_signed && SrcA[31]) ? (32'd0 - SrcA) : SrcA;
  assign dvs_mag    = (div_signed && SrcB[31]) ? (32'd0 - SrcB) : SrcB;
  // zero divisor is replaced so the divider never sees x/0; that result is overridden anyway
  assign dvs_safe   = (dvs_mag == 32'd0) ? 32'd1 : dvs_mag;
  assign uq         = dvd_mag / dvs_safe;
  assign ur         = dvd_mag % dvs_safe;
  assign quo        = neg_q ? (32'd0 - uq) : uq;
  assign rem        = neg_r ? (32'd0 - ur) : ur;

`ifdef MDU_MADD_EN
  assign is_long = (MDUCtrl != OP_MTHI) && (MDUCtrl != OP_MTLO);
`else
  assign is_long = ~MDUCtrl[2];
`endif
  assign is_div = (MDUCtrl == OP_DIV) || (MDUCtrl == OP_DIVU);

  // Select the 64-bit {hi,lo} result of the requested long operation
  always_comb begin
    result = 64'd0;
    case (MDUCtrl)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV, OP_DIVU: begin
        if (SrcB == 32'd0) result = {SrcA, 32'hFFFF_FFFF};
        else               result = {rem, quo};
      end
`ifdef MDU_MADD_EN
      // accumulator is the architectural {hi,lo} at the Start edge; Busy blocks later writes
      OP_MADD:  result = {hi_q, lo_q} + prod_s;
      OP_MADDU: result = {hi_q, lo_q} + prod_u;
`endif
      default:  result = 64'd0;
    endcase
  end

  // State register: counter, pending result and the architectural HI/LO pair
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= 4'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      pend_q <= 64'd0;
    end else begin
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      pend_q <= pend_d;
    end
  end

  // Next state: count down in RUN and commit on the last edge; in IDLE accept a request
  always_comb begin
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    pend_d = pend_q;
    if (cnt_q != 4'd0) begin
      // Start is ignored while running
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        hi_d = pend_q[63:32];
        lo_d = pend_q[31:0];
      end
    end else if (Start) begin
      if (MDUCtrl == OP_MTHI) begin
        hi_d = SrcA;
      end else if (MDUCtrl == OP_MTLO) begin
        lo_d = SrcA;
      end else if (is_long) begin
        pend_d = result;
        cnt_d  = is_div ? DIV_N : MULT_N;
      end
    end
  end

  // Outputs come straight from registers
  always_comb begin
    Busy = (cnt_q != 4'd0);
    hi   = hi_q;
    lo   = lo_q;
  end

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - scoreboard bench for mdu_seq against a plain-arithmetic reference model
module tb_mdu_seq;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk     = 1'b0;
  logic        reset   = 1'b0;
  logic        Start   = 1'b0;
  logic [2:0]  MDUCtrl = 3'd0;
  logic [31:0] SrcA    = 32'd0;
  logic [31:0] SrcB    = 32'd0;
  logic [31:0] hi, lo;
  logic        Busy;

  mdu_seq #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .SrcA(SrcA), .SrcB(SrcB), .Start(Start),
    .MDUCtrl(MDUCtrl), .hi(hi), .lo(lo), .Busy(Busy)
  );

  always #5 clk = ~clk;

  // number of rising edges seen so far
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic        b;
    logic [31:0] h;
    logic [31:0] l;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   draining    = 1'b0;
  event kick;

  // reference model: committed HI/LO and the cycle at which the last long op lands
  logic [31:0] m_hi  = 32'd0;
  logic [31:0] m_lo  = 32'd0;
  int          m_end = 0;

  // monitor: compare every expectation due at the current cycle
  always @(negedge clk or kick) begin
    exp_t x;
    while (sb.size() > 0 && (sb[0].c <= cyc || draining)) begin
      x = sb.pop_front();
      vectors++;
      if (x.c != cyc) begin
        miscompares++;
        $display("FAIL %s: check due at cycle %0d never sampled (now cycle %0d)", x.tag, x.c, cyc);
      end else if (Busy !== x.b || hi !== x.h || lo !== x.l) begin
        miscompares++;
        $display("FAIL %s cycle %0d: got Busy=%b hi=%h lo=%h, want Busy=%b hi=%h lo=%h",
                 x.tag, cyc, Busy, hi, lo, x.b, x.h, x.l);
      end
    end
  end

  task automatic push(input int c, input logic b, input logic [31:0] h, input logic [31:0] l,
                      input string tag);
    exp_t x;
    x.c = c; x.b = b; x.h = h; x.l = l; x.tag = tag;
    sb.push_back(x);
  endtask

  function automatic bit is_long(input logic [2:0] op);
`ifdef MDU_MADD_EN
    return (op != 3'd4) && (op != 3'd5);
`else
    return op < 3'd4;
`endif
  endfunction

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] acc);
    int                sa, sb2, q, rm;
    longint            sp;
    longint unsigned   up;
    sa  = a;
    sb2 = b;
    sp  = longint'(sa) * longint'(sb2);
    up  = {32'd0, a} * {32'd0, b};
    case (op)
      3'd0: return sp;
      3'd1: return up;
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q  = sa / sb2;
        rm = sa % sb2;
        return {rm, q};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      3'd6: return acc + sp;
      3'd7: return acc + up;
      default: return acc;
    endcase
  endfunction

  // one cycle of stimulus: drive inputs, record what the next edge must produce
  task automatic step(input logic st, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input string tag);
    int          e, n;
    logic [63:0] r;
    Start   = st;
    MDUCtrl = op;
    SrcA    = a;
    SrcB    = b;
    e = cyc + 1;
    if (e > m_end) begin
      if (st && is_long(op)) begin
        r = model(op, a, b, {m_hi, m_lo});
        n = (op == 3'd2 || op == 3'd3) ? DC : MC;
        for (int k = 0; k < n; k++) push(e + k, 1'b1, m_hi, m_lo, tag);
        m_hi  = r[63:32];
        m_lo  = r[31:0];
        m_end = e + n;
        push(e + n, 1'b0, m_hi, m_lo, tag);
      end else begin
        if (st && op == 3'd4) m_hi = a;
        if (st && op == 3'd5) m_lo = a;
        push(e, 1'b0, m_hi, m_lo, tag);
      end
    end
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic wait_done(input bit stray);
    int guard;
    guard = 0;
    while (cyc + 1 <= m_end && guard < 40) begin
      step(stray && ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), $urandom, $urandom, "stray");
      guard++;
    end
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // power-on reset with a request held high: nothing may happen
    SrcA = 32'h0000_1234; SrcB = 32'd5; MDUCtrl = 3'd4; Start = 1'b1;
    repeat (3) begin
      push(cyc + 1, 1'b0, 32'd0, 32'd0, "por");
      @(negedge clk);
    end
    reset = 1'b1;
    Start = 1'b0;
    m_end = cyc;
    step(1'b0, 3'd0, 32'd0, 32'd0, "idle");
    step(1'b0, 3'd0, 32'd0, 32'd0, "idle");

    step(1'b1, 3'd0, 32'hFFFF_FFFE, 32'd3, "mult");
    wait_done(1'b0);
    step(1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3, "multu");
    wait_done(1'b0);

    step(1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, "div");
    wait_done(1'b0);
    step(1'b1, 3'd3, 32'd7, 32'd0, "divu0");
    wait_done(1'b0);

    step(1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    step(1'b0, 3'd0, 32'd0, 32'd0, "div_ovf");
    step(1'b1, 3'd4, 32'hDEAD_BEEF, 32'd0, "mthi_busy");
    step(1'b1, 3'd4, 32'hDEAD_BEEF, 32'd0, "mthi_busy");
    wait_done(1'b0);

    step(1'b1, 3'd5, 32'h1234_5678, 32'd0, "mtlo");
    step(1'b0, 3'd0, 32'd0, 32'd0, "mtlo_idle");

    // request held across the completion edge: ignored there, taken one edge later
    step(1'b1, 3'd1, rnd_op(), rnd_op(), "multu_fall");
    while (cyc + 1 < m_end) step(1'b0, 3'd0, 32'd0, 32'd0, "multu_fall");
    step(1'b1, 3'd4, 32'hCAFE_F00D, 32'd0, "mthi_at_fall");
    step(1'b1, 3'd4, 32'hCAFE_F00D, 32'd0, "mthi_after_fall");
    step(1'b0, 3'd0, 32'd0, 32'd0, "idle");

    step(1'b1, 3'd4, 32'd0, 32'd0, "mthi0");
    step(1'b1, 3'd5, 32'hFFFF_FFFF, 32'd0, "mtlo_ones");
    step(1'b1, 3'd7, 32'd1, 32'd1, "maddu");
    wait_done(1'b0);
    step(1'b1, 3'd6, 32'hFFFF_FFFF, 32'd5, "madd");
    wait_done(1'b0);
    step(1'b0, 3'd0, 32'd0, 32'd0, "idle");

    repeat (40) begin
      step(1'b1, 3'($urandom_range(0, 7)), rnd_op(), rnd_op(), "rand");
      wait_done(1'b1);
    end

    // asynchronous reset in the middle of a multiply (three cycles left)
    step(1'b1, 3'd0, 32'h7FFF_FFFF, 32'h0000_0003, "mult_rst");
    step(1'b0, 3'd0, 32'd0, 32'd0, "mult_rst");
    step(1'b0, 3'd0, 32'd0, 32'd0, "mult_rst");
    #1 reset = 1'b0;
    while (sb.size() > 0 && sb[sb.size() - 1].c > cyc) void'(sb.pop_back());
    #1 push(cyc, 1'b0, 32'd0, 32'd0, "rst_async");
    -> kick;
    m_hi  = 32'd0;
    m_lo  = 32'd0;
    m_end = cyc;
    push(cyc + 1, 1'b0, 32'd0, 32'd0, "rst_hold");
    @(negedge clk);
    reset = 1'b1;
    repeat (MC + 3) step(1'b0, 3'd0, 32'd0, 32'd0, "post_rst");

    repeat (2) @(negedge clk);
    draining = 1'b1;
    #1 -> kick;
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
